// File: rtl/vend_pkg.sv
// Shared types and helpers for the vend sequencer slice.
// Contents: coin_t payload enum, seq_state_t FSM encoding, change-code
// constants and change_to_nickels() decode.
package vend_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    NICKEL  = 2'b01,
    DIME    = 2'b10,
    QUARTER = 2'b11
  } coin_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FEED,
    ST_GAP,
    ST_CHECK,
    ST_VEND_REQ,
    ST_VEND_REL,
    ST_CHG_REQ,
    ST_CHG_REL,
    ST_FAULT
  } seq_state_t;

  localparam logic [2:0] CHG_0  = 3'b000;
  localparam logic [2:0] CHG_5  = 3'b001;
  localparam logic [2:0] CHG_10 = 3'b010;
  localparam logic [2:0] CHG_20 = 3'b100;

  // True for the four legal one-hot-or-zero change codes.
  function automatic logic change_valid(input logic [2:0] code);
    return (code == CHG_0) || (code == CHG_5) || (code == CHG_10) || (code == CHG_20);
  endfunction

  // Number of nickels to pay out for a change code (0 for illegal codes).
  function automatic logic [2:0] change_to_nickels(input logic [2:0] code);
    logic [2:0] n;
    case (code)
      CHG_5:   n = 3'd1;
      CHG_10:  n = 3'd2;
      CHG_20:  n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/coin_fifo.sv
// Synchronous coin queue.
// Ports: clk, rst_n (async active-low), push/din write side, pop/head_c read
// side (head_c is the combinational head entry), count (registered
// occupancy) and count_next_c (occupancy after this cycle's push/pop).
module coin_fifo
  import vend_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  coin_t                    din,
  input  logic                     pop,
  output coin_t                    head_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  coin_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head_c = mem[rd_ptr];

  // Occupancy update; caller guarantees no push when full, no pop when empty.
  always_comb begin
    count_next_c = count;
    case ({push, pop})
      2'b10:   count_next_c = count + CNT_W'(1);
      2'b01:   count_next_c = count - CNT_W'(1);
      default: count_next_c = count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next_c;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vend_sequencer.sv
// Sequencer between the coin mechanism / vend hardware and the FSM core.
// Buffers coins, feeds them to the core one at a time (pulse, gap, check),
// then runs the soda-motor and nickel-hopper 4-phase handshakes.
// Ports: i_clk, i_rst_n; coin intake i_coin_valid/i_coin_type/o_coin_ready;
// core side o_fsm_nickle/o_fsm_dime/o_fsm_quarter, i_fsm_soda, i_fsm_change;
// handshakes o_vend_req/i_vend_ack, o_nickel_req/i_nickel_ack;
// status o_busy, o_fault (sticky until reset).
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_coin_valid,
  input  logic [1:0] i_coin_type,
  output logic       o_coin_ready,
  output logic       o_fsm_nickle,
  output logic       o_fsm_dime,
  output logic       o_fsm_quarter,
  input  logic       i_fsm_soda,
  input  logic [2:0] i_fsm_change,
  output logic       o_vend_req,
  input  logic       i_vend_ack,
  output logic       o_nickel_req,
  input  logic       i_nickel_ack,
  output logic       o_busy,
  output logic       o_fault
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [2:0]       nick_cnt;
  logic [2:0]       nick_nxt;
  logic [TMR_W-1:0] tmr;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] fifo_count_nxt;
  coin_t            head;
  logic             push;
  logic             pop;
  logic             timeout;
  logic             in_hs;

  // Readiness comes from registered state only, so a same-cycle pop never frees space.
  assign push = i_coin_valid & o_coin_ready & (i_coin_type != 2'b00);

  coin_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (i_clk),
    .rst_n        (i_rst_n),
    .push         (push),
    .din          (coin_t'(i_coin_type)),
    .pop          (pop),
    .head_c       (head),
    .count        (fifo_count),
    .count_next_c (fifo_count_nxt)
  );

  assign in_hs   = (state == ST_VEND_REQ) || (state == ST_VEND_REL) ||
                   (state == ST_CHG_REQ)  || (state == ST_CHG_REL);
  assign timeout = (tmr >= TMR_W'(ACK_TIMEOUT));

  // State register and nickel payout count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      nick_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      nick_cnt <= nick_nxt;
    end
  end

  // Next-state logic. Ack is only honoured once our req is visibly high.
  always_comb begin
    state_nxt = state;
    nick_nxt  = nick_cnt;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fifo_count != '0) begin
          pop       = 1'b1;
          state_nxt = ST_FEED;
        end
      end
      ST_FEED:  state_nxt = ST_GAP;
      ST_GAP:   state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (!i_fsm_soda) begin
          state_nxt = ST_IDLE;
        end else if (change_valid(i_fsm_change)) begin
          nick_nxt  = change_to_nickels(i_fsm_change);
          state_nxt = ST_VEND_REQ;
        end else begin
          state_nxt = ST_FAULT;
        end
      end
      ST_VEND_REQ: begin
        if (o_vend_req && i_vend_ack) state_nxt = ST_VEND_REL;
        else if (timeout)             state_nxt = ST_FAULT;
      end
      ST_VEND_REL: begin
        if (!i_vend_ack)  state_nxt = (nick_cnt != 3'd0) ? ST_CHG_REQ : ST_IDLE;
        else if (timeout) state_nxt = ST_FAULT;
      end
      ST_CHG_REQ: begin
        if (o_nickel_req && i_nickel_ack) state_nxt = ST_CHG_REL;
        else if (timeout)                 state_nxt = ST_FAULT;
      end
      ST_CHG_REL: begin
        if (!i_nickel_ack) begin
          nick_nxt  = nick_cnt - 3'd1;
          state_nxt = (nick_cnt == 3'd1) ? ST_IDLE : ST_CHG_REQ;
        end else if (timeout) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_FAULT;
    endcase
  end

  // Per-phase watchdog: restarts on every state change, runs only in handshake states.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                tmr <= '0;
    else if (state_nxt != state) tmr <= '0;
    else if (in_hs)              tmr <= tmr + TMR_W'(1);
    else                         tmr <= '0;
  end

  // Registered outputs; req drops on the edge that leaves its REQ state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_coin_ready  <= 1'b1;
      o_fsm_nickle  <= 1'b0;
      o_fsm_dime    <= 1'b0;
      o_fsm_quarter <= 1'b0;
      o_vend_req    <= 1'b0;
      o_nickel_req  <= 1'b0;
      o_busy        <= 1'b0;
      o_fault       <= 1'b0;
    end else begin
      o_coin_ready  <= (fifo_count_nxt < CNT_W'(FIFO_DEPTH)) && (state_nxt != ST_FAULT);
      o_fsm_nickle  <= pop && (head == NICKEL);
      o_fsm_dime    <= pop && (head == DIME);
      o_fsm_quarter <= pop && (head == QUARTER);
      o_vend_req    <= (state == ST_VEND_REQ) && (state_nxt == ST_VEND_REQ);
      o_nickel_req  <= (state == ST_CHG_REQ) && (state_nxt == ST_CHG_REQ);
      o_busy        <= (state_nxt != ST_IDLE) || (fifo_count_nxt != '0);
      o_fault       <= (state_nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: a 20c-accumulator model of the
// core, auto/forced ack responders, a scenario table and directed corner cases.
module tb_vend_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 32;
  localparam logic [1:0] C_X = 2'b00;
  localparam logic [1:0] C_N = 2'b01;
  localparam logic [1:0] C_D = 2'b10;
  localparam logic [1:0] C_Q = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       coin_ready;
  logic       fsm_nickle, fsm_dime, fsm_quarter;
  logic       fsm_soda;
  logic [2:0] fsm_change;
  logic       vend_req, vend_ack;
  logic       nickel_req, nickel_ack;
  logic       busy, fault;

  vend_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .ACK_TIMEOUT (TMO)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_coin_valid  (coin_valid),
    .i_coin_type   (coin_type),
    .o_coin_ready  (coin_ready),
    .o_fsm_nickle  (fsm_nickle),
    .o_fsm_dime    (fsm_dime),
    .o_fsm_quarter (fsm_quarter),
    .i_fsm_soda    (fsm_soda),
    .i_fsm_change  (fsm_change),
    .o_vend_req    (vend_req),
    .i_vend_ack    (vend_ack),
    .o_nickel_req  (nickel_req),
    .i_nickel_ack  (nickel_ack),
    .o_busy        (busy),
    .o_fault       (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Event monitors, sampled on the falling edge.
  int cyc = 0, pulses = 0, vends = 0, nickels = 0;
  int onehot_err = 0, spacing_err = 0, last_pulse = -100, npulse = 0;
  logic vend_prev = 1'b0, nick_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    npulse = int'(fsm_nickle) + int'(fsm_dime) + int'(fsm_quarter);
    if (npulse > 1) onehot_err++;
    if (npulse != 0) begin
      pulses++;
      if (cyc - last_pulse < 3) spacing_err++;
      last_pulse = cyc;
    end
    if (vend_req && !vend_prev)   vends++;
    if (nickel_req && !nick_prev) nickels++;
    vend_prev = vend_req;
    nick_prev = nickel_req;
  end

  // Ack responders and a 20c-price core model holding its outputs until the next coin.
  logic vend_auto, vend_force, nick_auto, nick_force;
  int   model_epoch = 0, seen_epoch = 0, credit = 0;

  function automatic logic [2:0] change_code(input int cents);
    case (cents)
      0:       return 3'b000;
      5:       return 3'b001;
      10:      return 3'b010;
      20:      return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

  always @(negedge clk) begin
    vend_ack   = vend_auto ? vend_req : vend_force;
    nickel_ack = nick_auto ? nickel_req : nick_force;
    if (!rst_n || model_epoch != seen_epoch) begin
      seen_epoch = model_epoch;
      credit     = 0;
      fsm_soda   = 1'b0;
      fsm_change = 3'b000;
    end else if (fsm_nickle || fsm_dime || fsm_quarter) begin
      credit += fsm_nickle ? 5 : (fsm_dime ? 10 : 25);
      if (credit >= 20) begin
        fsm_soda   = 1'b1;
        fsm_change = change_code(credit - 20);
        credit     = 0;
      end else begin
        fsm_soda   = 1'b0;
        fsm_change = 3'b000;
      end
    end
  end

  typedef struct {
    string           name;
    logic [2:0][1:0] coins;
    int              ncoins;
    int              exp_pulses;
    int              exp_vends;
    int              exp_nickels;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [1:0] c0, input logic [1:0] c1,
                              input logic [1:0] c2, input int n, input int p, input int v,
                              input int k);
    vec_t r;
    r.name = nm;
    r.coins[0] = c0;
    r.coins[1] = c1;
    r.coins[2] = c2;
    r.ncoins = n;
    r.exp_pulses = p;
    r.exp_vends = v;
    r.exp_nickels = k;
    return r;
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(busy), 0);
  endtask

  task automatic wait_high_nickel(input string name);
    int n;
    n = 0;
    while (!nickel_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(nickel_req), 1);
  endtask

  task automatic send_one(input logic [1:0] t);
    @(negedge clk);
    coin_valid = 1'b1;
    coin_type  = t;
    @(negedge clk);
    coin_valid = 1'b0;
  endtask

  vec_t tbl [8];

  initial begin
    int p0, v0, k0, n;

    rst_n = 1'b0;
    coin_valid = 1'b0;
    coin_type = 2'b00;
    vend_auto = 1'b1;
    vend_force = 1'b0;
    nick_auto = 1'b1;
    nick_force = 1'b0;

    tbl[0] = mk("nnd", C_N, C_N, C_D, 3, 3, 1, 0);
    tbl[1] = mk("nq",  C_N, C_Q, C_X, 2, 2, 1, 2);
    tbl[2] = mk("q",   C_Q, C_X, C_X, 1, 1, 1, 1);
    tbl[3] = mk("dd",  C_D, C_D, C_X, 2, 2, 1, 0);
    tbl[4] = mk("qq",  C_Q, C_Q, C_X, 2, 2, 2, 2);
    tbl[5] = mk("n0n", C_N, C_X, C_N, 3, 2, 0, 0);
    tbl[6] = mk("d0d", C_D, C_X, C_D, 3, 2, 1, 0);
    tbl[7] = mk("qn",  C_Q, C_N, C_X, 2, 2, 1, 1);

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_ready", int'(coin_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_vend_req", int'(vend_req), 0);
    check("rst_nickel_req", int'(nickel_req), 0);
    check("rst_pulses", int'(fsm_nickle | fsm_dime | fsm_quarter), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_ready", int'(coin_ready), 1);
    check("post_rst_busy", int'(busy), 0);

    // Minimum push-to-pulse latency and single-cycle pulse.
    model_epoch++;
    @(negedge clk);
    coin_valid = 1'b1;
    coin_type  = C_D;
    @(negedge clk);
    coin_valid = 1'b0;
    check("lat_c1_dime", int'(fsm_dime), 0);
    check("lat_c1_busy", int'(busy), 1);
    @(negedge clk);
    check("lat_c2_dime", int'(fsm_dime), 1);
    check("lat_c2_others", int'(fsm_nickle | fsm_quarter), 0);
    @(negedge clk);
    check("lat_c3_dime", int'(fsm_dime), 0);
    wait_idle("lat_idle");

    // Scenario table.
    for (int i = 0; i < 8; i++) begin
      model_epoch++;
      @(negedge clk);
      p0 = pulses;
      v0 = vends;
      k0 = nickels;
      for (int j = 0; j < tbl[i].ncoins; j++) begin
        @(negedge clk);
        coin_valid = 1'b1;
        coin_type  = tbl[i].coins[j];
      end
      @(negedge clk);
      coin_valid = 1'b0;
      wait_idle({tbl[i].name, "_idle"});
      check({tbl[i].name, "_pulses"}, pulses - p0, tbl[i].exp_pulses);
      check({tbl[i].name, "_vends"}, vends - v0, tbl[i].exp_vends);
      check({tbl[i].name, "_nickels"}, nickels - k0, tbl[i].exp_nickels);
      check({tbl[i].name, "_ready"}, int'(coin_ready), 1);
    end

    // FIFO fills while the vend handshake is stalled.
    vend_auto = 1'b0;
    vend_force = 1'b0;
    model_epoch++;
    @(negedge clk);
    p0 = pulses;
    v0 = vends;
    k0 = nickels;
    send_one(C_Q);
    n = 0;
    while (!vend_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stall_req_up", int'(vend_req), 1);
    for (int j = 0; j < 4; j++) begin
      if (j == 3) check("stall_ready_before_full", int'(coin_ready), 1);
      coin_valid = 1'b1;
      coin_type  = C_D;
      @(negedge clk);
    end
    check("stall_full_ready", int'(coin_ready), 0);
    @(negedge clk);
    coin_valid = 1'b0;
    check("stall_reject_ready", int'(coin_ready), 0);
    check("stall_req_held", int'(vend_req), 1);
    check("stall_no_feed", pulses - p0, 1);
    vend_auto = 1'b1;
    wait_idle("stall_idle");
    check("stall_pulses", pulses - p0, 5);
    check("stall_vends", vends - v0, 3);
    check("stall_nickels", nickels - k0, 1);
    check("stall_ready_after", int'(coin_ready), 1);

    // Hopper never acks: fault after exactly TMO cycles of req high.
    nick_auto = 1'b0;
    nick_force = 1'b0;
    model_epoch++;
    @(negedge clk);
    send_one(C_Q);
    wait_high_nickel("tmo_req_up");
    n = 0;
    while (!fault && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", n, int'(TMO));
    check("tmo_nickel_req", int'(nickel_req), 0);
    check("tmo_vend_req", int'(vend_req), 0);
    check("tmo_ready", int'(coin_ready), 0);
    p0 = pulses;
    send_one(C_N);
    repeat (6) @(negedge clk);
    check("tmo_no_feed", pulses - p0, 0);
    check("tmo_fault_sticky", int'(fault), 1);
    check("tmo_ready_sticky", int'(coin_ready), 0);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("fault_cleared", int'(fault), 0);
    check("fault_rst_ready", int'(coin_ready), 1);

    // Reset in the middle of a hopper handshake with coins queued.
    model_epoch++;
    @(negedge clk);
    send_one(C_Q);
    wait_high_nickel("mid_req_up");
    coin_valid = 1'b1;
    coin_type  = C_N;
    @(negedge clk);
    @(negedge clk);
    coin_valid = 1'b0;
    check("mid_busy_queued", int'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_async_drop", int'(nickel_req), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(coin_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pulses;
    repeat (8) @(negedge clk);
    check("mid_fifo_empty", pulses - p0, 0);
    check("mid_idle", int'(busy), 0);

    check("onehot_pulses", onehot_err, 0);
    check("pulse_spacing", spacing_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
